// File: rtl/bus_slave_port_pkg.sv
// Shared bus definitions: default widths, slave FSM states, command encoding.
package bus_slave_port_pkg;

  localparam int unsigned SLAVE_LEN_DEF    = 2;
  localparam int unsigned ADDR_LEN_DEF     = 12;
  localparam int unsigned DATA_LEN_DEF     = 8;
  localparam int unsigned BURST_LEN_DEF    = 12;
  localparam int unsigned MEM_ADDR_LEN_DEF = 12;

  // Slave-side burst engine states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_FETCH,
    ST_SEND,
    ST_DONE
  } state_t;

  // Request direction as carried on req_write (shared with the master side)
  typedef enum logic {
    CMD_READ  = 1'b0,
    CMD_WRITE = 1'b1
  } cmd_t;

endpackage

// File: rtl/slave_mem.sv
// Single-port synchronous RAM with a registered, resettable read port.
module slave_mem #(
  parameter int unsigned DATA_LEN = 8,
  parameter int unsigned ADDR_LEN = 12
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                we,
  input  logic                re,
  input  logic [ADDR_LEN-1:0] addr,
  input  logic [DATA_LEN-1:0] wdata,
  output logic [DATA_LEN-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_LEN;

  logic [DATA_LEN-1:0] mem [DEPTH];

  // Write port: storage is never cleared by reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Read port: output register holds its value until the next read strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/bus_slave_port.sv
// Bus slave responder: accepts read/write bursts for its select value and
// serves them from local synchronous memory, pulsing done on completion.
module bus_slave_port
  import bus_slave_port_pkg::*;
#(
  parameter int unsigned SLAVE_LEN    = SLAVE_LEN_DEF,
  parameter int unsigned SLAVE_ID     = 0,
  parameter int unsigned ADDR_LEN     = ADDR_LEN_DEF,
  parameter int unsigned DATA_LEN     = DATA_LEN_DEF,
  parameter int unsigned BURST_LEN    = BURST_LEN_DEF,
  parameter int unsigned MEM_ADDR_LEN = MEM_ADDR_LEN_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [SLAVE_LEN-1:0] req_sel,
  input  logic                 req_write,
  input  logic [ADDR_LEN-1:0]  req_addr,
  input  logic [BURST_LEN-1:0] req_burst,
  input  logic                 wdata_valid,
  output logic                 wdata_ready,
  input  logic [DATA_LEN-1:0]  wdata,
  output logic                 rdata_valid,
  input  logic                 rdata_ready,
  output logic [DATA_LEN-1:0]  rdata,
  output logic                 done,
  output logic                 busy
);

  state_t                  state;
  logic [MEM_ADDR_LEN-1:0] addr_q;
  logic [BURST_LEN-1:0]    remaining_q;
  logic                    sel_match;
  logic                    mem_we;
  logic                    mem_re;

  assign sel_match = (req_sel == SLAVE_LEN'(SLAVE_ID));
  assign req_ready = (state == ST_IDLE) && sel_match;

  // A beat presented on the reset edge is dropped so an abort never adds data
  assign mem_we = !reset && (state == ST_WRITE) && wdata_valid;
  assign mem_re = (state == ST_FETCH);

  slave_mem #(
    .DATA_LEN (DATA_LEN),
    .ADDR_LEN (MEM_ADDR_LEN)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (addr_q),
    .wdata (wdata),
    .rdata (rdata)
  );

  // Burst FSM with address/beat counters; handshake outputs are registered
  // and updated together with the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      wdata_ready <= 1'b0;
      rdata_valid <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid && sel_match) begin
            addr_q      <= req_addr[MEM_ADDR_LEN-1:0];
            remaining_q <= (req_burst == '0) ? BURST_LEN'(1) : req_burst;
            busy        <= 1'b1;
            if (req_write == CMD_WRITE) begin
              state       <= ST_WRITE;
              wdata_ready <= 1'b1;
            end else begin
              state <= ST_FETCH;
            end
          end
        end
        ST_WRITE: begin
          if (wdata_valid) begin
            addr_q      <= addr_q + MEM_ADDR_LEN'(1);
            remaining_q <= remaining_q - BURST_LEN'(1);
            if (remaining_q == BURST_LEN'(1)) begin
              state       <= ST_DONE;
              wdata_ready <= 1'b0;
              done        <= 1'b1;
            end
          end
        end
        ST_FETCH: begin
          state       <= ST_SEND;
          rdata_valid <= 1'b1;
        end
        ST_SEND: begin
          if (rdata_ready) begin
            rdata_valid <= 1'b0;
            addr_q      <= addr_q + MEM_ADDR_LEN'(1);
            remaining_q <= remaining_q - BURST_LEN'(1);
            if (remaining_q == BURST_LEN'(1)) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_FETCH;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state       <= ST_IDLE;
          wdata_ready <= 1'b0;
          rdata_valid <= 1'b0;
          done        <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_slave_port.sv
// Scoreboard bench for bus_slave_port: directed scenarios plus random bursts
// checked against an array memory model.
module tb_bus_slave_port;

  localparam int unsigned SID   = 0;
  localparam int unsigned DEPTH = 4096;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_sel;
  logic        req_write;
  logic [11:0] req_addr;
  logic [11:0] req_burst;
  logic        wdata_valid;
  logic        wdata_ready;
  logic [7:0]  wdata;
  logic        rdata_valid;
  logic        rdata_ready;
  logic [7:0]  rdata;
  logic        done;
  logic        busy;

  always #5 clk = ~clk;

  bus_slave_port #(
    .SLAVE_LEN    (2),
    .SLAVE_ID     (SID),
    .ADDR_LEN     (12),
    .DATA_LEN     (8),
    .BURST_LEN    (12),
    .MEM_ADDR_LEN (12)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_sel     (req_sel),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_burst   (req_burst),
    .wdata_valid (wdata_valid),
    .wdata_ready (wdata_ready),
    .wdata       (wdata),
    .rdata_valid (rdata_valid),
    .rdata_ready (rdata_ready),
    .rdata       (rdata),
    .done        (done),
    .busy        (busy)
  );

  typedef struct {
    logic [7:0] d;
    bit         known;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] ref_mem[DEPTH];
  bit         ref_known[DEPTH];
  int         tests = 0;
  int         fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int wrap_addr(input logic [11:0] base, input int off);
    return (int'(base) + off) % DEPTH;
  endfunction

  // Monitor: every read handshake pops the next expected beat
  always @(negedge clk) begin
    if (!reset && rdata_valid && rdata_ready) begin
      if (exp_q.size() == 0) begin
        chk("rdata_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.known) chk("rdata", {24'd0, rdata}, {24'd0, e.d});
      end
    end
  end

  task automatic issue_req(input bit wr, input logic [1:0] sel, input logic [11:0] addr,
                           input logic [11:0] burst, output bit ok);
    req_valid = 1'b1;
    req_write = wr;
    req_sel   = sel;
    req_addr  = addr;
    req_burst = burst;
    #1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
      #1;
    end
    if (!ok) chk("req_timeout", 32'd0, 32'd1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic write_burst(input logic [11:0] addr, input logic [11:0] burst,
                             input logic [7:0] data[$], input bit gaps);
    bit ok;
    int n;
    n = (burst == 0) ? 1 : int'(burst);
    issue_req(1'b1, 2'(SID), addr, burst, ok);
    if (!ok) return;
    for (int i = 0; i < n; i++) begin
      bit got;
      if (gaps) begin
        repeat ($urandom_range(0, 1)) begin
          wdata_valid = 1'b0;
          tick();
        end
      end
      wdata_valid = 1'b1;
      wdata       = data[i];
      #1;
      got = 1'b0;
      for (int t = 0; t < 20; t++) begin
        if (wdata_ready) begin
          got = 1'b1;
          break;
        end
        tick();
        #1;
      end
      if (!got) begin
        chk("wdata_timeout", 32'd0, 32'd1);
        wdata_valid = 1'b0;
        return;
      end
      tick();
      ref_mem[wrap_addr(addr, i)]   = data[i];
      ref_known[wrap_addr(addr, i)] = 1'b1;
    end
    wdata_valid = 1'b0;
    chk("wr_done_pulse", {31'd0, done}, 32'd1);
    tick();
    chk("wr_done_clear", {31'd0, done}, 32'd0);
    chk("wr_busy_idle", {31'd0, busy}, 32'd0);
  endtask

  // ready_rand: randomize rdata_ready; stall: cycles to hold the first beat
  task automatic read_burst(input logic [11:0] addr, input logic [11:0] burst,
                            input bit ready_rand, input int stall);
    bit ok;
    int n;
    int hs;
    int cycles;
    int stalled;
    int a0;
    n = (burst == 0) ? 1 : int'(burst);
    a0 = wrap_addr(addr, 0);
    issue_req(1'b0, 2'(SID), addr, burst, ok);
    if (!ok) return;
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.d     = ref_mem[wrap_addr(addr, i)];
      e.known = ref_known[wrap_addr(addr, i)];
      exp_q.push_back(e);
    end
    hs      = 0;
    cycles  = 0;
    stalled = 0;
    for (int t = 0; t < 400 && hs < n; t++) begin
      if (stall > 0 && hs == 0 && rdata_valid && stalled < stall) begin
        rdata_ready = 1'b0;
        chk("bp_valid", {31'd0, rdata_valid}, 32'd1);
        if (ref_known[a0]) chk("bp_rdata", {24'd0, rdata}, {24'd0, ref_mem[a0]});
        chk("bp_busy", {31'd0, busy}, 32'd1);
        stalled++;
      end else begin
        rdata_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      #1;
      if (rdata_valid && rdata_ready) hs++;
      tick();
      cycles++;
    end
    rdata_ready = 1'b0;
    if (hs < n) begin
      chk("rd_timeout", 32'(hs), 32'(n));
      return;
    end
    if (stall > 0) chk("bp_stall_cycles", 32'(stalled), 32'(stall));
    chk("rd_done_pulse", {31'd0, done}, 32'd1);
    if (!ready_rand && stall == 0) chk("rd_cycles", 32'(cycles), 32'(2 * n));
    tick();
    chk("rd_done_clear", {31'd0, done}, 32'd0);
    chk("rd_busy_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] wq[$];
    bit         ok;
    for (int i = 0; i < int'(DEPTH); i++) ref_known[i] = 1'b0;
    reset       = 1'b1;
    req_valid   = 1'b0;
    req_sel     = 2'(SID);
    req_write   = 1'b0;
    req_addr    = '0;
    req_burst   = '0;
    wdata_valid = 1'b0;
    wdata       = '0;
    rdata_ready = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_wdata_ready", {31'd0, wdata_ready}, 32'd0);
    chk("rst_rdata_valid", {31'd0, rdata_valid}, 32'd0);
    chk("rst_rdata", {24'd0, rdata}, 32'd0);
    chk("rst_req_ready_match", {31'd0, req_ready}, 32'd1);
    req_sel = 2'd1;
    #1;
    chk("rst_req_ready_nomatch", {31'd0, req_ready}, 32'd0);
    req_sel = 2'(SID);
    reset = 1'b0;
    tick();

    // Basic write then read-back
    wq.delete(); wq.push_back(8'hA1); wq.push_back(8'hA2); wq.push_back(8'hA3);
    write_burst(12'h010, 12'd3, wq, 1'b0);
    read_burst(12'h010, 12'd3, 1'b0, 0);

    // Address wrap
    wq.delete(); wq.push_back(8'h55); wq.push_back(8'h66);
    write_burst(12'hFFF, 12'd2, wq, 1'b0);
    read_burst(12'h000, 12'd1, 1'b0, 0);
    read_burst(12'hFFF, 12'd1, 1'b0, 0);

    // Wrong select is ignored, even with write data offered
    req_valid   = 1'b1;
    req_sel     = 2'd2;
    req_write   = 1'b1;
    req_addr    = 12'h010;
    req_burst   = 12'd1;
    wdata_valid = 1'b1;
    wdata       = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("badsel_req_ready", {31'd0, req_ready}, 32'd0);
      chk("badsel_busy", {31'd0, busy}, 32'd0);
      tick();
    end
    req_valid   = 1'b0;
    wdata_valid = 1'b0;
    read_burst(12'h010, 12'd3, 1'b0, 0);

    // Burst 0 carries exactly one beat
    wq.delete(); wq.push_back(8'h88);
    write_burst(12'h101, 12'd1, wq, 1'b0);
    wq.delete(); wq.push_back(8'h77);
    write_burst(12'h100, 12'd0, wq, 1'b0);
    read_burst(12'h100, 12'd2, 1'b0, 0);
    read_burst(12'h100, 12'd0, 1'b0, 0);

    // Read backpressure
    read_burst(12'h010, 12'd2, 1'b0, 5);

    // Reset in the middle of a write burst
    wq.delete(); wq.push_back(8'h10); wq.push_back(8'h20); wq.push_back(8'h30); wq.push_back(8'h40);
    write_burst(12'h200, 12'd4, wq, 1'b0);
    issue_req(1'b1, 2'(SID), 12'h200, 12'd4, ok);
    wdata_valid = 1'b1;
    wdata       = 8'hB1;
    #1;
    chk("mid_wdata_ready", {31'd0, wdata_ready}, 32'd1);
    tick();
    ref_mem[12'h200] = 8'hB1;
    wdata  = 8'hB2;
    reset  = 1'b1;
    tick();
    reset       = 1'b0;
    wdata_valid = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_wdata_ready", {31'd0, wdata_ready}, 32'd0);
    tick();
    chk("abort_done_later", {31'd0, done}, 32'd0);
    read_burst(12'h200, 12'd4, 1'b0, 0);

    // Random traffic
    for (int it = 0; it < 40; it++) begin
      logic [11:0] a;
      logic [11:0] b;
      int          n;
      a = 12'($urandom_range(4080, 4111));
      b = 12'($urandom_range(0, 6));
      n = (b == 0) ? 1 : int'(b);
      if ($urandom_range(0, 3) == 0) begin
        req_valid = 1'b1;
        req_sel   = 2'($urandom_range(1, 3));
        #1;
        chk("rand_badsel", {31'd0, req_ready}, 32'd0);
        tick();
        req_valid = 1'b0;
        req_sel   = 2'(SID);
      end
      if ($urandom_range(0, 1) == 1) begin
        wq.delete();
        for (int k = 0; k < n; k++) wq.push_back(8'($urandom));
        write_burst(a, b, wq, 1'b1);
      end else begin
        read_burst(a, b, 1'b1, 0);
      end
    end

    repeat (3) tick();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bus_slave_port.md
# bus_slave_port

Responder end of the system bus: accepts read/write burst requests addressed to its slave ID, serves them from a local synchronous memory, and signals completion back toward the requesting master. It sits between the bus arbiter/mux outputs and a slave's storage. It is the counterpart to the master-side command issuer.

## Interface

- SLAVE_LEN, 2, width of slave select
- SLAVE_ID, 0, select value this port answers to
- ADDR_LEN, 12, request address width
- DATA_LEN, 8, data beat width
- BURST_LEN, 12, burst count width
- MEM_ADDR_LEN, 12, local memory address width (depth 2**MEM_ADDR_LEN)
- clk  in  1  clock; reset is synchronous, active-high, named reset
- reset  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted this cycle when high with req_valid
- req_sel  in  SLAVE_LEN  target slave select
- req_write  in  1  1 = write burst, 0 = read burst
- req_addr  in  ADDR_LEN  start address
- req_burst  in  BURST_LEN  beat count (0 treated as 1)
- wdata_valid  in  1  write beat present
- wdata_ready  out  1  write beat accepted when high with wdata_valid
- wdata  in  DATA_LEN  write beat
- rdata_valid  out  1  read beat present
- rdata_ready  in  1  master takes read beat
- rdata  out  DATA_LEN  read beat
- done  out  1  one-cycle pulse at burst completion
- busy  out  1  high in any state except IDLE

## Operation

- States: IDLE, WRITE, FETCH, SEND, DONE.
- IDLE: req_ready = (req_sel == SLAVE_ID). On req_valid && req_ready: latch addr = req_addr[MEM_ADDR_LEN-1:0], remaining = max(req_burst,1); go WRITE if req_write else FETCH. Non-matching req_sel: ignored, stay IDLE.
- WRITE: wdata_ready = 1. On wdata_valid: mem[addr] <= wdata, addr <= addr+1, remaining <= remaining-1; if remaining == 1 go DONE.
- FETCH: mem read of addr registered into rdata; go SEND.
- SEND: rdata_valid = 1, rdata held stable until rdata_ready. On rdata_ready: addr+1, remaining-1; if remaining == 1 go DONE else FETCH.
- DONE: done = 1 for exactly one cycle; go IDLE.
- Address increments wrap modulo 2**MEM_ADDR_LEN (0xFFF+1 -> 0x000). Upper req_addr bits beyond MEM_ADDR_LEN ignored.
- remaining counter is BURST_LEN bits; max burst 2**BURST_LEN-1 beats.
- Requests arriving while busy are not accepted (req_ready = 0); master must hold req_valid.

## Timing

- Reset: state IDLE, req_ready per req_sel match (combinational), wdata_ready 0, rdata_valid 0, rdata 0, done 0, busy 0, addr 0, remaining 0. Memory contents not cleared.
- Reset asserted mid-burst: aborts immediately next edge; no done pulse; partially written beats remain in memory.
- Write: beat written on the same edge it is accepted; back-to-back beats at 1/cycle. done pulses the cycle after the last beat's acceptance.
- Read: request accept edge -> FETCH (1 cycle) -> rdata_valid next cycle. Max throughput 1 beat per 2 cycles. done pulses the cycle after the last rdata handshake.
- Read-after-write across bursts returns new data (write completes before DONE).
- req_ready is only ever high in IDLE; busy = !IDLE.

## Structure

- Shared bus package: state encoding constants, default widths (SLAVE_LEN, ADDR_LEN, DATA_LEN, BURST_LEN), instruction encoding shared with master side.
- One sub-module: slave_mem, single-port synchronous RAM (write-first irrelevant; never read and write same cycle), DATA_LEN x 2**MEM_ADDR_LEN.
- FSM, address/remaining counters, and handshake logic in bus_slave_port top.

## Test plan

- Reset then write burst: sel=SLAVE_ID, addr 0x010, burst 3, beats A1,A2,A3 -> mem[0x010..0x012]=A1,A2,A3, done one pulse one cycle after A3.
- Read back same range with burst 3, rdata_ready always 1 -> rdata A1,A2,A3 on alternate cycles, done after third.
- Wrap: write burst 2 at 0xFFF (55,66), read 0x000 burst 1 -> 66; read 0xFFF -> 55.
- Wrong select: req_sel != SLAVE_ID with req_valid -> req_ready 0, busy stays 0, memory unchanged; burst 0 request -> exactly one beat.
- Backpressure: read burst 2, rdata_ready low 5 cycles -> rdata_valid and rdata stable throughout, addr not advanced.
- Reset mid-write after 1 of 4 beats -> IDLE next cycle, no done, first beat retained, next request accepted normally.
